// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand/opcode sequencer: {funct,opcode} codes,
// legality mask, instruction field offsets and the sequencer state encoding.
package alu_seq_pkg;

    localparam logic [3:0] CODE_0 = 4'h0;
    localparam logic [3:0] CODE_1 = 4'h1;
    localparam logic [3:0] CODE_2 = 4'h2;
    localparam logic [3:0] CODE_3 = 4'h3;
    localparam logic [3:0] CODE_4 = 4'h4;
    localparam logic [3:0] CODE_5 = 4'h5;
    localparam logic [3:0] CODE_6 = 4'h6;
    localparam logic [3:0] CODE_7 = 4'h7;
    localparam logic [3:0] CODE_8 = 4'h8;
    localparam logic [3:0] CODE_9 = 4'h9;
    localparam logic [3:0] CODE_A = 4'hA;
    localparam logic [3:0] CODE_B = 4'hB;
    localparam logic [3:0] CODE_C = 4'hC;
    localparam logic [3:0] CODE_D = 4'hD;
    localparam logic [3:0] CODE_E = 4'hE;
    localparam logic [3:0] CODE_F = 4'hF;

    // One bit per {funct,opcode}; codes 8, B, E and F are left clear
    localparam logic [15:0] LEGAL_MASK =
        (16'd1 << CODE_0) | (16'd1 << CODE_1) | (16'd1 << CODE_2) | (16'd1 << CODE_3) |
        (16'd1 << CODE_4) | (16'd1 << CODE_5) | (16'd1 << CODE_6) | (16'd1 << CODE_7) |
        (16'd1 << CODE_9) | (16'd1 << CODE_A) | (16'd1 << CODE_C) | (16'd1 << CODE_D);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic int off_li(input int bl);     return bl + 10; endfunction
    function automatic int off_funct(input int bl);  return bl + 9;  endfunction
    function automatic int off_opcode(input int bl); return bl + 6;  endfunction
    function automatic int off_rd(input int bl);     return bl + 4;  endfunction
    function automatic int off_rs1(input int bl);    return bl + 2;  endfunction
    function automatic int off_rs2(input int bl);    return bl;      endfunction

    function automatic logic code_legal(input logic [3:0] code);
        return LEGAL_MASK[code];
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Four-entry operand register file: two combinational read ports, one
// synchronous write port, asynchronous active-low clear.
module alu_seq_regfile #(
    parameter int BIT_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [1:0]            waddr,
    input  logic [BIT_LENGTH-1:0] wdata,
    input  logic [1:0]            raddr_a,
    input  logic [1:0]            raddr_b,
    output logic [BIT_LENGTH-1:0] rdata_a,
    output logic [BIT_LENGTH-1:0] rdata_b
);

    logic [BIT_LENGTH-1:0] regs [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU operand/opcode interface: accepts instructions, issues
// one ALU cycle, writes back and returns the result. Option: ALU_SEQ_PERF_CNT_EN.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int BIT_LENGTH = 4,
    localparam int INSTR_W    = BIT_LENGTH + 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr_data,
    output logic [BIT_LENGTH-1:0] alu_a,
    output logic [BIT_LENGTH-1:0] alu_b,
    output logic [2:0]            alu_opcode,
    output logic                  alu_funct,
    output logic                  alu_exec_en,
    input  logic [BIT_LENGTH-1:0] alu_out,
    input  logic                  alu_cb,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [BIT_LENGTH-1:0] res_data,
    output logic                  res_cb,
    output logic                  res_err,
    output logic                  busy
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]           op_count
`endif
);

    localparam int LI_BIT  = off_li(BIT_LENGTH);
    localparam int FN_BIT  = off_funct(BIT_LENGTH);
    localparam int OPC_LO  = off_opcode(BIT_LENGTH);
    localparam int RD_LO   = off_rd(BIT_LENGTH);
    localparam int RS1_LO  = off_rs1(BIT_LENGTH);
    localparam int RS2_LO  = off_rs2(BIT_LENGTH);

    state_t state, state_nxt;

    logic                  accept, in_li, in_legal, in_issue;
    logic [3:0]            in_code;
    logic [BIT_LENGTH-1:0] in_imm;
    logic [1:0]            rd_q, rs1_q, rs2_q;
    logic [2:0]            opcode_q;
    logic                  funct_q;
    logic [BIT_LENGTH-1:0] res_data_q, rdata_a, rdata_b;
    logic                  res_err_q, res_from_alu_q, carry_flag;
    logic                  rf_we;
    logic [1:0]            rf_waddr;
    logic [BIT_LENGTH-1:0] rf_wdata;

    assign in_li    = instr_data[LI_BIT];
    assign in_code  = {instr_data[FN_BIT], instr_data[OPC_LO +: 3]};
    assign in_imm   = instr_data[BIT_LENGTH-1:0];
    assign in_legal = code_legal(in_code);
    assign accept   = instr_valid && (state == IDLE);
    assign in_issue = (state == ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (!in_li && in_legal) ? ISSUE : RESP;
            ISSUE:   state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction fields only matter while not IDLE, so they carry no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q     <= instr_data[RD_LO +: 2];
            rs1_q    <= instr_data[RS1_LO +: 2];
            rs2_q    <= instr_data[RS2_LO +: 2];
            opcode_q <= in_code[2:0];
            funct_q  <= in_code[3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q     <= '0;
            res_err_q      <= 1'b0;
            res_from_alu_q <= 1'b0;
            carry_flag     <= 1'b0;
        end else if (accept && in_li) begin
            res_data_q     <= in_imm;
            res_err_q      <= 1'b0;
            res_from_alu_q <= 1'b0;
        end else if (accept && !in_legal) begin
            res_data_q     <= '0;
            res_err_q      <= 1'b1;
            res_from_alu_q <= 1'b0;
        end else if (in_issue) begin
            res_data_q     <= alu_out;
            res_err_q      <= 1'b0;
            res_from_alu_q <= 1'b1;
            carry_flag     <= alu_cb;
        end
    end

    // LI writes at the accept edge; ALU results write at the ISSUE exit edge
    assign rf_we    = (accept && in_li) || in_issue;
    assign rf_waddr = in_issue ? rd_q : instr_data[RD_LO +: 2];
    assign rf_wdata = in_issue ? alu_out : in_imm;

    alu_seq_regfile #(.BIT_LENGTH(BIT_LENGTH)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs1_q),
        .raddr_b (rs2_q),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    assign alu_exec_en = in_issue;
    assign alu_a       = in_issue ? rdata_a  : '0;
    assign alu_b       = in_issue ? rdata_b  : '0;
    assign alu_opcode  = in_issue ? opcode_q : 3'b000;
    assign alu_funct   = in_issue ? funct_q  : 1'b0;

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign res_valid   = (state == RESP);
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    // The carry flag was loaded by the same ISSUE edge that produced this result
    assign res_cb      = res_from_alu_q && carry_flag;

`ifdef ALU_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            op_count <= 16'd0;
        else if (in_issue && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table of instructions with expected results fed
// through a response queue, plus hand sequences for stall and mid-ISSUE reset.
module tb_alu_op_sequencer;

    localparam int BL = 4;
    localparam int IW = BL + 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [IW-1:0] instr_data = '0;
    logic [BL-1:0] alu_a, alu_b, alu_out;
    logic [2:0]    alu_opcode;
    logic          alu_funct, alu_exec_en, alu_cb;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [BL-1:0] res_data;
    logic          res_cb, res_err, busy;
`ifdef ALU_SEQ_PERF_CNT_EN
    logic [15:0]   op_count;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer #(.BIT_LENGTH(BL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_funct   (alu_funct),
        .alu_exec_en (alu_exec_en),
        .alu_out     (alu_out),
        .alu_cb      (alu_cb),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_cb      (res_cb),
        .res_err     (res_err),
        .busy        (busy)
`ifdef ALU_SEQ_PERF_CNT_EN
        ,
        .op_count    (op_count)
`endif
    );

    // Stand-in ALU: 0000 add, 0001 sub, 0010 and, 0011 or, anything else passes a
    logic [BL:0] alu_wide;
    always_comb begin
        alu_wide = {1'b0, alu_a};
        case ({alu_funct, alu_opcode})
            4'b0000: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            4'b0010: alu_wide = {1'b0, alu_a & alu_b};
            4'b0011: alu_wide = {1'b0, alu_a | alu_b};
            default: alu_wide = {1'b0, alu_a};
        endcase
    end
    assign alu_out = alu_wide[BL-1:0];
    assign alu_cb  = alu_wide[BL];

    typedef struct {
        logic          li;
        logic [3:0]    code;
        logic [1:0]    rd, rs1, rs2;
        logic [BL-1:0] imm;
        logic [BL-1:0] ea, eb;
        logic [BL-1:0] ed;
        logic          ecb, eerr;
        int            hold;
    } rec_t;

    typedef struct {
        logic [BL-1:0] d;
        logic          cb, err;
    } resp_t;

    resp_t exp_q[$];
    rec_t  tbl[15];
    int    checks = 0;
    int    errors = 0;
    int    exp_ops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic rec_t mk(input logic li, input logic [3:0] code, input logic [1:0] rd,
                                input logic [1:0] rs1, input logic [1:0] rs2, input logic [BL-1:0] imm,
                                input logic [BL-1:0] ea, input logic [BL-1:0] eb, input logic [BL-1:0] ed,
                                input logic ecb, input logic eerr, input int hold);
        rec_t r;
        r.li = li; r.code = code; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        r.ea = ea; r.eb = eb; r.ed = ed; r.ecb = ecb; r.eerr = eerr; r.hold = hold;
        return r;
    endfunction

    task automatic run_rec(input rec_t r, input string tag);
        int guard;
        logic is_alu;
        logic [BL-1:0] snap;
        resp_t e;
        is_alu = !r.li && !r.eerr;
        guard = 0;
        @(negedge clk);
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " instr_ready_wait"}, {31'd0, instr_ready}, 32'd1);
        instr_data  = {r.li, r.code, r.rd, r.rs1, r.rs2, r.imm};
        instr_valid = 1'b1;
        exp_q.push_back('{d: r.ed, cb: r.ecb, err: r.eerr});
        @(posedge clk);
        #1 instr_valid = 1'b0;
        if (is_alu) begin
            chk({tag, " issue exec_en/opc/funct"}, {28'd0, alu_exec_en, alu_funct, alu_opcode},
                {28'd0, 1'b1, r.code});
            chk({tag, " issue a/b"}, {24'd0, alu_a, alu_b}, {24'd0, r.ea, r.eb});
            chk({tag, " issue res_valid"}, {31'd0, res_valid}, 32'd0);
            @(posedge clk);
            #1;
            exp_ops++;
        end else begin
            chk({tag, " exec_en idle"}, {31'd0, alu_exec_en}, 32'd0);
        end
        chk({tag, " resp valid/busy/ready"}, {29'd0, res_valid, busy, instr_ready}, {29'd0, 3'b110});
        snap = res_data;
        for (int i = 0; i < r.hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " stall hold"}, {24'd0, res_valid, busy, instr_ready, res_data, alu_exec_en},
                {24'd0, 3'b110, snap, 1'b0});
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " res_data"}, {28'd0, res_data}, {28'd0, e.d});
            chk({tag, " res_cb/err"}, {30'd0, res_cb, res_err}, {30'd0, e.cb, e.err});
        end
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk({tag, " post_handshake valid/ready"}, {30'd0, res_valid, instr_ready}, {30'd0, 2'b01});
    endtask

    initial begin
        //           li   code   rd  rs1  rs2  imm   ea    eb    ed    cb  err hold
        tbl[0]  = mk(1, 4'h0, 0, 0, 0, 4'h5, 4'h0, 4'h0, 4'h5, 0, 0, 0);
        tbl[1]  = mk(1, 4'h0, 1, 0, 0, 4'h3, 4'h0, 4'h0, 4'h3, 0, 0, 0);
        tbl[2]  = mk(0, 4'h0, 2, 0, 1, 4'h6, 4'h5, 4'h3, 4'h8, 0, 0, 0);
        tbl[3]  = mk(1, 4'h0, 0, 0, 0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 0);
        tbl[4]  = mk(1, 4'h0, 1, 0, 0, 4'h1, 4'h0, 4'h0, 4'h1, 0, 0, 1);
        tbl[5]  = mk(0, 4'h0, 2, 0, 1, 4'h6, 4'hF, 4'h1, 4'h0, 1, 0, 0);
        tbl[6]  = mk(0, 4'h1, 3, 1, 0, 4'h6, 4'h1, 4'hF, 4'h2, 1, 0, 2);
        tbl[7]  = mk(1, 4'h0, 2, 0, 0, 4'hA, 4'h0, 4'h0, 4'hA, 0, 0, 0);
        tbl[8]  = mk(0, 4'h8, 2, 0, 0, 4'h6, 4'h0, 4'h0, 4'h0, 0, 1, 5);
        tbl[9]  = mk(0, 4'h3, 3, 2, 2, 4'h6, 4'hA, 4'hA, 4'hA, 0, 0, 0);
        tbl[10] = mk(0, 4'h2, 1, 1, 3, 4'h6, 4'h1, 4'hA, 4'h0, 0, 0, 0);
        tbl[11] = mk(0, 4'hB, 0, 0, 0, 4'h6, 4'h0, 4'h0, 4'h0, 0, 1, 0);
        tbl[12] = mk(0, 4'hD, 0, 0, 1, 4'h6, 4'hF, 4'h0, 4'hF, 0, 0, 0);
        tbl[13] = mk(0, 4'hF, 3, 0, 0, 4'h6, 4'h0, 4'h0, 4'h0, 0, 1, 0);
        tbl[14] = mk(0, 4'h9, 1, 2, 3, 4'h6, 4'hA, 4'hA, 4'hA, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset ready/valid/busy", {29'd0, instr_ready, res_valid, busy}, {29'd0, 3'b100});
        chk("reset alu drive", {20'd0, alu_exec_en, alu_funct, alu_opcode, alu_a, alu_b},
            {20'd0, 12'd0});
        chk("reset res_data/cb/err", {26'd0, res_data, res_cb, res_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_rec(tbl[i], $sformatf("vec%0d", i));

`ifdef ALU_SEQ_PERF_CNT_EN
        chk("op_count", {16'd0, op_count}, exp_ops);
`endif

        // Reset pulled low in the middle of an ISSUE cycle
        @(negedge clk);
        instr_data  = {1'b0, 4'h0, 2'd2, 2'd0, 2'd1, 4'h0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        chk("midrst issue exec_en", {31'd0, alu_exec_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst ready/valid/busy/exec", {28'd0, instr_ready, res_valid, busy, alu_exec_en},
            {28'd0, 4'b1000});
        chk("midrst alu_a/b/res_data", {20'd0, alu_a, alu_b, res_data}, 32'd0);
        exp_ops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_rec(mk(0, 4'h0, 2, 0, 1, 4'h6, 4'h0, 4'h0, 4'h0, 0, 0, 0), "post_reset_add");

`ifdef ALU_SEQ_PERF_CNT_EN
        chk("op_count after reset", {16'd0, op_count}, exp_ops);
`endif
        chk("queue drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/opcode interface.
- Accepts instruction words over a valid/ready handshake and holds a 4-entry operand register file.
- Drives a, b, opcode, funct and exec_en into the combinational ALU for one cycle, then captures out/cb and writes back.
- Returns each result over a valid/ready response channel; sits between the instruction source and the ALU instance at top level.

Parameters:
- BIT_LENGTH, 4, datapath width; matches the ALU's BIT_LENGTH.
- INSTR_W, BIT_LENGTH+11, instruction word width; derived, not overridden.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction word present.
- instr_ready  output  1  sequencer can accept an instruction.
- instr_data  input  INSTR_W  fields: [BL+10] is_li, [BL+9] funct, [BL+8:BL+6] opcode, [BL+5:BL+4] rd, [BL+3:BL+2] rs1, [BL+1:BL] rs2, [BL-1:0] imm (BL=BIT_LENGTH).
- alu_a  output  BIT_LENGTH  ALU operand a.
- alu_b  output  BIT_LENGTH  ALU operand b.
- alu_opcode  output  3  ALU opcode.
- alu_funct  output  1  ALU funct.
- alu_exec_en  output  1  ALU execute enable.
- alu_out  input  BIT_LENGTH  ALU result.
- alu_cb  input  1  ALU carry/borrow.
- res_valid  output  1  response present.
- res_ready  input  1  consumer accepts response.
- res_data  output  BIT_LENGTH  result value.
- res_cb  output  1  carry/borrow of result.
- res_err  output  1  illegal instruction flag.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs 0, except instr_ready = 1. State = IDLE, regfile r0..r3 = 0, carry flag = 0. Reset is asynchronous, so it takes effect mid-operation and any in-flight instruction is dropped.
- States and transitions:
  - IDLE: instr_ready = 1. On an accept edge (instr_valid && instr_ready), latch instr_data.
    - is_li = 1: write imm to rd at the accept edge, load res_data = imm, res_cb = 0, res_err = 0, then go to RESP.
    - ALU op with a legal {funct,opcode}: go to ISSUE.
    - ALU op with an illegal {funct,opcode}: res_err = 1, res_data = 0, res_cb = 0, no regfile write, go to RESP.
  - ISSUE (exactly 1 cycle): alu_exec_en = 1; alu_a = r[rs1], alu_b = r[rs2] read from registered state; opcode and funct come from the latched instruction. At the exiting edge, write alu_out to r[rd], load res_data/res_cb, update the carry flag, then go to RESP.
  - RESP: res_valid = 1, with res_data/res_cb/res_err stable until res_ready. On the handshake edge go to IDLE and clear res_valid.
- Legal {funct,opcode}: 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1001, 1010, 1100, 1101.
- Illegal: 1000, 1011, 1110, 1111. For these alu_exec_en never rises.
- Outside ISSUE: alu_exec_en, alu_a, alu_b, alu_opcode and alu_funct are all driven 0.
- Latency from the accept edge to res_valid: ALU op, 2 cycles; LI or illegal, 1 cycle.
- Throughput: at most one instruction in flight. instr_ready = 0 from the accept edge until the cycle after the response handshake.
- rd may equal rs1 or rs2: operands are read during ISSUE, before the write.
- rs1 may equal rs2.
- No wrap logic is needed. Width overflow is taken entirely from alu_cb; the sequencer does no arithmetic.

Optional Feature:
- Macro ALU_SEQ_PERF_CNT_EN.
- Defined: adds output op_count [15:0], reset to 0. It increments on each ISSUE exit edge and saturates at 0xFFFF; LI and illegal instructions do not count.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg holds:
  - localparams for all 16 {funct,opcode} codes and the legal mask;
  - instruction field offsets as functions of BIT_LENGTH;
  - the state enum IDLE/ISSUE/RESP.
- Sub-module alu_seq_regfile: 4 x BIT_LENGTH registers, 2 async read ports, 1 sync write port, async active-low clear.
- The ALU is instantiated beside the sequencer, not inside it.

Test Plan:
- LI r0=5, LI r1=3, then ADD r2=r0+r1 -> the ISSUE cycle shows exec_en=1, opcode=000, a=5, b=3; response is res_data=8, res_cb=0, res_valid 2 cycles after accept.
- LI r0=0xF, LI r1=1, ADD r2 -> res_data=0x0, res_cb=1. Then SUB r3=r1-r0 -> res_data=0x2, res_cb=1.
- Illegal {1,000} -> res_err=1, res_data=0, exec_en stays 0 throughout. A following OR r3=r2|r2 returns the unchanged r2.
- res_ready held low 5 cycles during RESP -> res_valid/res_data stable, instr_ready=0, busy=1. instr_ready=1 one cycle after the handshake.
- rst_n pulled low during ISSUE -> all outputs 0 immediately. After release: instr_ready=1, and ADD r0+r1 returns 0.
- With ALU_SEQ_PERF_CNT_EN defined: 3 ALU ops + 2 LI + 1 illegal -> op_count=3.
